// File: rtl/ak6502_bus_timer.sv
// ak6502_bus_timer: 16-bit memory-mapped interval timer, a responder on the
// AK6502 external bus. The CPU drives addr/rw/din and the ph2 strobe (en).
// The block decodes a 16-byte window at BASE, returns read data on dout,
// accepts register writes and drives the CPU irq_n input.
//
// Ports:
//   clk    - system clock, all state on the rising edge
//   rst    - asynchronous active-high reset
//   addr   - CPU address bus
//   din    - write data from the CPU
//   dout   - read data (combinational), 8'h00 when not selected or unmapped
//   rw     - 1 = read, 0 = write
//   en     - bus strobe; one access per cycle while high
//   sel    - combinational window decode for the external read mux
//   irq_n  - registered active-low interrupt request
//
// Register map (offset = addr[3:0]):
//   0 CNT_LO  R    count[7:0]; a read latches count[15:8] into the shadow
//   1 CNT_HI  R    shadow of count[15:8]
//   2 RLD_LO  R/W  reload[7:0]
//   3 RLD_HI  R/W  reload[15:8]; write also loads count and restarts prescaler
//   4 CTRL    R/W  bit0 EN, bit1 AUTO, bit2 IE
//   5 STATUS  R/W1C bit0 UF
//   6..15     read 0, writes ignored

module ak6502_bus_timer #(
    parameter logic [15:0] BASE     = 16'hD000,
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    input  logic        rw,
    input  logic        en,
    output logic        sel,
    output logic        irq_n
);

    localparam int unsigned CW = 16;
    localparam int unsigned PW = 16;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    localparam logic [3:0] OFF_CNT_LO = 4'd0;
    localparam logic [3:0] OFF_CNT_HI = 4'd1;
    localparam logic [3:0] OFF_RLD_LO = 4'd2;
    localparam logic [3:0] OFF_RLD_HI = 4'd3;
    localparam logic [3:0] OFF_CTRL   = 4'd4;
    localparam logic [3:0] OFF_STATUS = 4'd5;

    // CTRL bit positions
    localparam int unsigned B_EN   = 0;
    localparam int unsigned B_AUTO = 1;
    localparam int unsigned B_IE   = 2;

    logic [CW-1:0] count_q,  count_d;
    logic [CW-1:0] reload_q, reload_d;
    logic [7:0]    shadow_q, shadow_d;
    logic [2:0]    ctrl_q,   ctrl_d;
    logic          uf_q,     uf_d;
    logic [PW-1:0] pre_q,    pre_d;
    logic          irq_n_q,  irq_n_d;

    logic [3:0] off;
    logic       rd_acc;
    logic       wr_acc;
    logic       tick;
    logic       uf_set;

    // Window decode and access qualification
    assign sel    = (addr[15:4] == BASE[15:4]);
    assign off    = addr[3:0];
    assign rd_acc = en & rw & sel;
    assign wr_acc = en & ~rw & sel;

    // Read data mux, valid in the same cycle as the access
    always_comb begin
        dout = 8'h00;
        if (sel) begin
            case (off)
                OFF_CNT_LO: dout = count_q[7:0];
                OFF_CNT_HI: dout = shadow_q;
                OFF_RLD_LO: dout = reload_q[7:0];
                OFF_RLD_HI: dout = reload_q[15:8];
                OFF_CTRL:   dout = {5'b0, ctrl_q};
                OFF_STATUS: dout = {7'b0, uf_q};
                default:    dout = 8'h00;
            endcase
        end
    end

    // Next-state: prescaler, counter, then bus writes (writes override the
    // counter path), with the underflow set applied last so it beats W1C.
    always_comb begin
        count_d  = count_q;
        reload_d = reload_q;
        shadow_d = shadow_q;
        ctrl_d   = ctrl_q;
        uf_d     = uf_q;
        pre_d    = pre_q;
        tick     = 1'b0;
        uf_set   = 1'b0;

        // Prescaler: counts 0..PRESCALE-1 while enabled, ticks on wrap
        if (ctrl_q[B_EN]) begin
            if (pre_q == PRE_LAST) begin
                tick  = 1'b1;
                pre_d = '0;
            end else begin
                pre_d = pre_q + 16'd1;
            end
        end else begin
            pre_d = '0;
        end

        // Counter: decrement, or underflow with reload / one-shot stop
        if (tick) begin
            if (count_q != '0) begin
                count_d = count_q - 16'd1;
            end else begin
                uf_set = 1'b1;
                if (ctrl_q[B_AUTO]) begin
                    count_d = reload_q;
                end else begin
                    count_d      = '0;
                    ctrl_d[B_EN] = 1'b0;
                end
            end
        end

        // CNT_LO read snapshots the high byte so a 16-bit read is coherent
        if (rd_acc && (off == OFF_CNT_LO)) begin
            shadow_d = count_q[15:8];
        end

        if (wr_acc) begin
            case (off)
                OFF_RLD_LO: begin
                    reload_d[7:0] = din;
                end
                OFF_RLD_HI: begin
                    reload_d[15:8] = din;
                    count_d        = {din, reload_q[7:0]};
                    pre_d          = '0;
                end
                OFF_CTRL: begin
                    ctrl_d = din[2:0];
                    // Fresh enable or disable both leave the prescaler at 0
                    if (!din[B_EN] || !ctrl_q[B_EN]) begin
                        pre_d = '0;
                    end
                end
                OFF_STATUS: begin
                    if (din[0]) begin
                        uf_d = 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end

        if (uf_set) begin
            uf_d = 1'b1;
        end

        irq_n_d = ~(uf_d & ctrl_d[B_IE]);
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= 16'hFFFF;
            reload_q <= 16'hFFFF;
            shadow_q <= 8'hFF;
            ctrl_q   <= 3'b000;
            uf_q     <= 1'b0;
            pre_q    <= '0;
            irq_n_q  <= 1'b1;
        end else begin
            count_q  <= count_d;
            reload_q <= reload_d;
            shadow_q <= shadow_d;
            ctrl_q   <= ctrl_d;
            uf_q     <= uf_d;
            pre_q    <= pre_d;
            irq_n_q  <= irq_n_d;
        end
    end

    assign irq_n = irq_n_q;

endmodule

// File: tb/tb_ak6502_bus_timer.sv
// tb_ak6502_bus_timer: directed bench for ak6502_bus_timer (PRESCALE=1).
// Bus tasks are entered on a falling edge, hold the access for one cycle
// and return on the next falling edge with en dropped.

module tb_ak6502_bus_timer;

    localparam logic [15:0] BASE = 16'hD000;

    logic        clk;
    logic        rst;
    logic [15:0] addr;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        rw;
    logic        en;
    logic        sel;
    logic        irq_n;

    int n_checks;
    int n_errors;

    ak6502_bus_timer #(
        .BASE     (BASE),
        .PRESCALE (1)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .addr  (addr),
        .din   (din),
        .dout  (dout),
        .rw    (rw),
        .en    (en),
        .sel   (sel),
        .irq_n (irq_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [3:0] off, input logic [7:0] data);
        addr = BASE | {12'h000, off};
        rw   = 1'b0;
        din  = data;
        en   = 1'b1;
        @(negedge clk);
        en   = 1'b0;
        rw   = 1'b1;
    endtask

    task automatic bus_rd(input logic [15:0] a, output logic [7:0] data);
        addr = a;
        rw   = 1'b1;
        en   = 1'b1;
        #1;
        data = dout;
        @(negedge clk);
        en   = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] off, input logic [7:0] exp);
        logic [7:0] d;
        bus_rd(BASE | {12'h000, off}, d);
        chk_eq(tag, 16'(d), 16'(exp));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Counts falling edges until irq_n goes low, bounded
    task automatic wait_irq(output int k);
        k = 0;
        while (irq_n && k < 40) begin
            @(negedge clk);
            k++;
        end
    endtask

    initial begin
        int k;
        n_checks = 0;
        n_errors = 0;
        rst  = 1'b1;
        en   = 1'b0;
        rw   = 1'b1;
        addr = 16'h0000;
        din  = 8'h00;
        @(negedge clk);
        rst = 1'b0;

        // Reset values
        chk_eq("rst_irq_n", 16'(irq_n), 16'h1);
        rd_chk("rst_cnt_lo", 4'd0, 8'hFF);
        rd_chk("rst_cnt_hi", 4'd1, 8'hFF);
        rd_chk("rst_rld_lo", 4'd2, 8'hFF);
        rd_chk("rst_rld_hi", 4'd3, 8'hFF);
        rd_chk("rst_ctrl",   4'd4, 8'h00);
        rd_chk("rst_status", 4'd5, 8'h00);
        rd_chk("unmapped_9", 4'd9, 8'h00);
        addr = 16'hC000; rw = 1'b1; en = 1'b1;
        #1;
        chk_eq("outside_sel",  16'(sel),  16'h0);
        chk_eq("outside_dout", 16'(dout), 16'h00);
        @(negedge clk);
        en = 1'b0;

        // Periodic mode, reload 3
        do_reset();
        bus_wr(4'd2, 8'h03);
        bus_wr(4'd3, 8'h00);
        bus_wr(4'd4, 8'h07);
        wait_irq(k);
        chk_eq("per_first_irq_delay", 16'(k), 16'd4);
        rd_chk("per_reload_cnt", 4'd0, 8'h03);
        bus_wr(4'd5, 8'h01);
        chk_eq("per_w1c_irq_n", 16'(irq_n), 16'h1);
        wait_irq(k);
        chk_eq("per_second_irq_delay", 16'(k), 16'd2);
        rd_chk("per_status", 4'd5, 8'h01);

        // One-shot, reload 2
        do_reset();
        bus_wr(4'd2, 8'h02);
        bus_wr(4'd3, 8'h00);
        bus_wr(4'd4, 8'h05);
        wait_irq(k);
        chk_eq("os_irq_delay", 16'(k), 16'd3);
        rd_chk("os_ctrl", 4'd4, 8'h04);
        idle(20);
        rd_chk("os_cnt_lo", 4'd0, 8'h00);
        rd_chk("os_cnt_hi", 4'd1, 8'h00);
        rd_chk("os_status", 4'd5, 8'h01);
        chk_eq("os_irq_held", 16'(irq_n), 16'h0);
        bus_wr(4'd5, 8'h01);
        idle(20);
        rd_chk("os_no_second_uf", 4'd5, 8'h00);
        chk_eq("os_irq_released", 16'(irq_n), 16'h1);

        // Latched 16-bit read across a low-byte borrow
        do_reset();
        bus_wr(4'd2, 8'h00);
        bus_wr(4'd3, 8'h01);
        bus_wr(4'd4, 8'h01);
        rd_chk("lat_cnt_lo_0100", 4'd0, 8'h00);
        idle(2);
        rd_chk("lat_cnt_hi_shadow", 4'd1, 8'h01);
        rd_chk("lat_cnt_lo_00fc", 4'd0, 8'hFC);
        rd_chk("lat_cnt_hi_00", 4'd1, 8'h00);

        // Collision: W1C in the underflow cycle, then RLD_HI in the underflow cycle
        do_reset();
        bus_wr(4'd2, 8'h03);
        bus_wr(4'd3, 8'h00);
        bus_wr(4'd4, 8'h07);
        idle(4);
        chk_eq("col_first_irq", 16'(irq_n), 16'h0);
        idle(3);
        bus_wr(4'd5, 8'h01);
        chk_eq("col_w1c_irq_n", 16'(irq_n), 16'h0);
        rd_chk("col_w1c_status", 4'd5, 8'h01);
        bus_wr(4'd5, 8'h01);
        idle(1);
        bus_wr(4'd3, 8'h02);
        rd_chk("col_rld_status", 4'd5, 8'h01);
        rd_chk("col_rld_cnt_lo", 4'd0, 8'h02);
        rd_chk("col_rld_cnt_hi", 4'd1, 8'h02);

        // Async reset between clock edges while irq is asserted
        do_reset();
        bus_wr(4'd2, 8'h05);
        bus_wr(4'd3, 8'h00);
        bus_wr(4'd4, 8'h07);
        idle(6);
        chk_eq("ar_pre_irq", 16'(irq_n), 16'h0);
        addr = BASE | 16'h0000; rw = 1'b1; en = 1'b1;
        #1;
        chk_eq("ar_pre_cnt", 16'(dout), 16'h05);
        #1;
        rst = 1'b1;
        #1;
        addr = BASE | 16'h0004;
        #1;
        chk_eq("ar_irq_n", 16'(irq_n), 16'h1);
        chk_eq("ar_ctrl", 16'(dout), 16'h00);
        @(negedge clk);
        en  = 1'b0;
        rst = 1'b0;
        rd_chk("ar_cnt_lo", 4'd0, 8'hFF);
        rd_chk("ar_cnt_hi", 4'd1, 8'hFF);
        rd_chk("ar_rld_lo", 4'd2, 8'hFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
